contador_nivel3: RTL and testbench
==================================

// Module: contador_nivel3
// PURPOSE
//  Parametrised BCD countdown timer (mm:ss) for the microwave controller, next generation of the level-2 counter.
//  Keypad digits shift in serially while idle. Start/pause/resume, a +30 s quick-add, a one-second tick prescaler
//  and a one-cycle done pulse are added. Sits between keypad decoder and 7-segment/magnetron control logic.
// PARAMETERS
//  MIN_DIGITS  1  number of BCD minute digits (1..3); max time = (10^MIN_DIGITS - 1):59
//  TICK_DIV    1  clock cycles per one-second decrement (1 = decrement every RUNNING cycle)
// PORTS
//  clock      in   1               single clock, all state on rising edge
//  clear      in   1               reset: synchronous, active-high
//  data       in   4               keypad digit for entry (BCD)
//  load_digit in   1               shift data into segundos (IDLE only)
//  start      in   1               start from IDLE / resume from PAUSED
//  pause      in   1               RUNNING -> PAUSED
//  add30      in   1               add 30 s (IDLE or RUNNING)
//  segundos   out  4               seconds units digit
//  dezenas    out  4               seconds tens digit (0..5 while running)
//  minutos    out  4*MIN_DIGITS    minute digits, LS digit in [3:0]
//  timer      out  1               1 while state == RUNNING (magnetron enable)
//  done       out  1               one-cycle pulse when countdown reaches 00:00
//  erro       out  1               one-cycle pulse on rejected start
//  estado     out  2               FSM state: 0 IDLE, 1 RUNNING, 2 PAUSED
// BEHAVIOUR
//  Reset (clear=1): all digits 0, estado IDLE, prescaler 0, timer/done/erro 0. Clear overrides every other input.
//  All outputs registered. Latency of every command: 1 clock.
//  IDLE:
//   - load_digit & data<=9: all digits shift one place up (MS minute digit lost), data -> segundos.
//   - load_digit & data>9: no change.
//   - load_digit beats start in the same cycle (start ignored).
//   - start: value nonzero and dezenas<=5 -> RUNNING, prescaler 0. Otherwise stay IDLE, erro=1 for one cycle.
//   - add30: value+30 s. If the value was 00:00, enter RUNNING (quick start).
//  RUNNING:
//   - Prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 decrement by one second.
//   - Borrow chain: segundos 0->9, dezenas 0->5, each minute digit 0->9.
//   - Decrement producing 00:00: same edge estado->IDLE, done=1 for exactly one cycle, timer=0.
//   - pause: -> PAUSED. Digits and prescaler held; the pause cycle's tick is discarded.
//   - add30: +30 s, that cycle's decrement skipped, prescaler restarts at 0. Priority: pause > add30 > tick.
//   - load_digit and start are ignored.
//  PAUSED:
//   - start -> RUNNING, prescaler continues from its held value.
//   - pause, add30 and load_digit are ignored.
//  add30 arithmetic (BCD):
//   - dezenas+3; if >5, subtract 6 and carry into minutes.
//   - Result above max saturates to all-9 minutes : 59.
//  timer = (estado==RUNNING). done and erro never both 1.
// STRUCTURE
//  contador_defs.vh (shared include):
//   - state encodings S_IDLE/S_RUNNING/S_PAUSED
//   - BCD_MAX=4'd9, SEC_TENS_MAX=4'd5, ADD_TENS=4'd3
//  Sub-module bcd_digito: one BCD digit with load, shift-in, decrement-with-borrow and add-with-carry;
//   modulus parameter (10 or 6). Instantiated 2+MIN_DIGITS times via generate.
//  Top keeps FSM, prescaler, entry/validation and saturation detect.
// TESTING
//  1) MIN_DIGITS=1, TICK_DIV=1; clear; shift 2,1,7,9; start:
//     - display 1:79 -> erro=1, stays IDLE.
//     - clear; shift 1,3,5; start -> 1:35 then 1:34 next cycle.
//     - done pulses once at 0:00 after 95 cycles; timer=0 thereafter.
//  2) MIN_DIGITS=2, TICK_DIV=4; load 00:02; start:
//     - 00:01 after 4 cycles, 00:00 + done after 8.
//     - pause at cycle 6: value frozen 10 cycles; resume -> 00:00 exactly 2 cycles later.
//  3) IDLE at 00:00; add30 -> 0:30 and RUNNING next cycle.
//     RUNNING at 0:45; add30 -> 1:15, prescaler reset.
//     Load 9:50 (MIN_DIGITS=1); add30 -> 9:59 saturated.
//  4) Borrow chain MIN_DIGITS=2: 10:00 -> 09:59 on one tick; load_digit during RUNNING ignored;
//     data=4'hC while IDLE -> no shift.
//  5) Simultaneous/reset cases:
//     - clear while RUNNING mid-prescale -> all zero, IDLE next cycle, no done.
//     - pause+add30 same cycle -> PAUSED, value unchanged.
//     - load_digit+start same cycle in IDLE -> shift only.

Source files
------------

// File: rtl/contador_nivel3_pkg.sv
// Shared definitions for the mm:ss BCD countdown timer.
//   state_t      : FSM encoding, also driven out on the estado port
//   BCD_MAX      : largest BCD digit value
//   SEC_TENS_MAX : largest seconds-tens digit value
//   ADD_TENS     : seconds-tens increment applied by the +30 s command
package contador_nivel3_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] ADD_TENS     = 4'd3;

endpackage

// File: rtl/contador_nivel3_if.sv
// Keypad-side command bus and display/control outputs of the countdown timer.
//   master : keypad decoder / controller side (drives commands, reads display)
//   slave  : the timer itself
//   data/load_digit/start/pause/add30 : commands, sampled on the rising clock edge
//   segundos/dezenas/minutos          : BCD display digits (minutes LS digit in [3:0])
//   timer/done/erro/estado            : magnetron enable, end pulse, reject pulse, FSM state
interface contador_nivel3_if #(
  parameter int MIN_DIGITS = 1
);
  logic [3:0]              data;
  logic                    load_digit;
  logic                    start;
  logic                    pause;
  logic                    add30;
  logic [3:0]              segundos;
  logic [3:0]              dezenas;
  logic [4*MIN_DIGITS-1:0] minutos;
  logic                    timer;
  logic                    done;
  logic                    erro;
  logic [1:0]              estado;

  modport master (
    output data, load_digit, start, pause, add30,
    input  segundos, dezenas, minutos, timer, done, erro, estado
  );

  modport slave (
    input  data, load_digit, start, pause, add30,
    output segundos, dezenas, minutos, timer, done, erro, estado
  );
endinterface

// File: rtl/contador_nivel3_bcd_digito.sv
// One BCD digit of the timer with modulus MOD (10 for units/minutes, 6 for seconds tens).
//   clock, clear : rising-edge clock, synchronous active-high clear
//   sat_en       : force MOD-1 (saturation), highest priority after clear
//   shift_en     : take shift_in (keypad entry shifting)
//   add_en       : q + addend + carry_in, wrapped once at MOD
//   dec_en       : decrement when borrow_in, 0 wraps to MOD-1
//   q            : digit value
module bcd_digito #(
  parameter logic [3:0] MOD = 4'd10
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       sat_en,
  input  logic       shift_en,
  input  logic       add_en,
  input  logic       dec_en,
  input  logic [3:0] shift_in,
  input  logic       borrow_in,
  input  logic [3:0] addend,
  input  logic       carry_in,
  output logic [3:0] q
);
  logic [3:0] q_q, q_d;
  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, q_q} + {1'b0, addend} + {4'b0, carry_in};
    q_d = q_q;
    if (sat_en)
      q_d = MOD - 4'd1;
    else if (shift_en)
      q_d = shift_in;
    else if (add_en)
      q_d = (sum >= {1'b0, MOD}) ? 4'(sum - {1'b0, MOD}) : sum[3:0];
    else if (dec_en && borrow_in)
      q_d = (q_q == 4'd0) ? MOD - 4'd1 : q_q - 4'd1;
  end

  always_ff @(posedge clock) begin
    if (clear) q_q <= 4'd0;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/contador_nivel3.sv
// BCD mm:ss countdown timer for the microwave controller.
//   clock, clear : rising-edge clock, synchronous active-high reset
//   bus          : command inputs and registered display/status outputs
// Digit chain index: 0 = seconds units, 1 = seconds tens, 2.. = minutes (LS first).
// The FSM, prescaler, entry validation and +30 s overflow detect live here; the
// digits themselves are bcd_digito instances sharing one set of strobes.
module contador_nivel3
  import contador_nivel3_pkg::*;
#(
  parameter int MIN_DIGITS = 1,
  parameter int TICK_DIV   = 1
) (
  input logic               clock,
  input logic               clear,
  contador_nivel3_if.slave  bus
);
  localparam int NDIG = 2 + MIN_DIGITS;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              done_q, done_d;
  logic              erro_q, erro_d;

  logic [NDIG-1:0][3:0] dig, sin, addend;
  logic [NDIG-1:0]      borrow, cin;
  logic                 shift_en, add_en, dec_en, sat_en;
  logic                 ovf, nonzero, is_one;

  // Shift moves every digit one place up; the top minute digit falls off.
  assign sin     = {dig[NDIG-2:0], bus.data};
  assign nonzero = |dig;
  assign is_one  = (dig[0] == 4'd1) && (dig[NDIG-1:1] == '0);

  // Borrow ripples up through zero digits. For +30 s only the tens digit gets an
  // addend; its carry then ripples through minute digits that are already 9.
  always_comb begin
    borrow    = '0;
    borrow[0] = 1'b1;
    for (int k = 1; k < NDIG; k++)
      borrow[k] = borrow[k-1] && (dig[k-1] == 4'd0);
    addend    = '0;
    addend[1] = ADD_TENS;
    cin       = '0;
    cin[2]    = ({1'b0, dig[1]} + {1'b0, ADD_TENS}) > {1'b0, SEC_TENS_MAX};
    for (int k = 3; k < NDIG; k++)
      cin[k] = cin[k-1] && (dig[k-1] == BCD_MAX);
    ovf = cin[NDIG-1] && (dig[NDIG-1] == BCD_MAX);
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digito #(
      .MOD((g == 1) ? SEC_TENS_MAX + 4'd1 : BCD_MAX + 4'd1)
    ) u_dig (
      .clock     (clock),
      .clear     (clear),
      .sat_en    (sat_en),
      .shift_en  (shift_en),
      .add_en    (add_en),
      .dec_en    (dec_en),
      .shift_in  (sin[g]),
      .borrow_in (borrow[g]),
      .addend    (addend[g]),
      .carry_in  (cin[g]),
      .q         (dig[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    erro_d   = 1'b0;
    shift_en = 1'b0;
    add_en   = 1'b0;
    dec_en   = 1'b0;
    sat_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // load_digit wins over start/add30; an invalid digit is simply dropped.
        if (bus.load_digit)
          shift_en = (bus.data <= BCD_MAX);
        else if (bus.start) begin
          if (nonzero && dig[1] <= SEC_TENS_MAX) begin
            state_d = S_RUNNING;
            presc_d = '0;
          end else
            erro_d = 1'b1;
        end else if (bus.add30) begin
          add_en = 1'b1;
          sat_en = ovf;
          if (!nonzero) begin        // quick start from 00:00
            state_d = S_RUNNING;
            presc_d = '0;
          end
        end
      end
      S_RUNNING: begin
        if (bus.pause)
          state_d = S_PAUSED;
        else if (bus.add30) begin    // this cycle's tick is dropped
          add_en  = 1'b1;
          sat_en  = ovf;
          presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          dec_en  = 1'b1;
          presc_d = '0;
          if (is_one) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else
          presc_d = presc_q + 1'b1;
      end
      S_PAUSED: begin
        if (bus.start) state_d = S_RUNNING;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      erro_q  <= erro_d;
    end
  end

  assign bus.segundos = dig[0];
  assign bus.dezenas  = dig[1];
  assign bus.minutos  = dig[NDIG-1:2];
  assign bus.timer    = (state_q == S_RUNNING);
  assign bus.done     = done_q;
  assign bus.erro     = erro_q;
  assign bus.estado   = state_q;
endmodule

// File: tb/tb_contador_nivel3.sv
// Bench for contador_nivel3: one instance with 1 minute digit / tick every cycle,
// one with 2 minute digits / tick every 4 cycles. Vectors carry commands and the
// expected mm:ss (as BCD hex), state, done and erro one clock later.
module tb_contador_nivel3;
  localparam logic [4:0] NOP = 5'd0, CLR = 5'd16, LD = 5'd8, ST = 5'd4, PA = 5'd2, AD = 5'd1;
  localparam logic [1:0] IDL = 2'd0, RUN = 2'd1, PSD = 2'd2;

  typedef struct {
    logic        d2;
    logic [4:0]  cmd;
    logic [3:0]  data;
    logic [15:0] disp;
    logic [1:0]  est;
    logic        dn;
    logic        er;
  } vec_t;

  logic clk = 1'b0;
  logic clr1, clr2;
  int   checks = 0, failures = 0, step = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  contador_nivel3_if #(.MIN_DIGITS(1)) if1 ();
  contador_nivel3_if #(.MIN_DIGITS(2)) if2 ();

  contador_nivel3 #(.MIN_DIGITS(1), .TICK_DIV(1)) dut1 (.clock(clk), .clear(clr1), .bus(if1.slave));
  contador_nivel3 #(.MIN_DIGITS(2), .TICK_DIV(4)) dut2 (.clock(clk), .clear(clr2), .bus(if2.slave));

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic d2, input logic [4:0] c, input logic [3:0] dat,
                              input logic [15:0] disp, input logic [1:0] est,
                              input logic dn, input logic er);
    vec_t v;
    v.d2 = d2; v.cmd = c; v.data = dat; v.disp = disp; v.est = est; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, expv);
    end
  endtask

  task automatic check_out();
    vec_t e;
    logic [15:0] disp;
    logic [1:0]  est;
    logic        tm, dn, er;
    e = exp_q.pop_front();
    if (e.d2) begin
      disp = {if2.minutos, if2.dezenas, if2.segundos};
      est = if2.estado; tm = if2.timer; dn = if2.done; er = if2.erro;
    end else begin
      disp = {4'h0, if1.minutos, if1.dezenas, if1.segundos};
      est = if1.estado; tm = if1.timer; dn = if1.done; er = if1.erro;
    end
    chk("display", disp, e.disp);
    chk("estado", 16'(est), 16'(e.est));
    chk("timer", 16'(tm), 16'(e.est == RUN));
    chk("done", 16'(dn), 16'(e.dn));
    chk("erro", 16'(er), 16'(e.er));
  endtask

  task automatic apply(input vec_t v);
    clr1 = 1'b0; clr2 = 1'b0;
    if1.data = 4'h0; if1.load_digit = 1'b0; if1.start = 1'b0; if1.pause = 1'b0; if1.add30 = 1'b0;
    if2.data = 4'h0; if2.load_digit = 1'b0; if2.start = 1'b0; if2.pause = 1'b0; if2.add30 = 1'b0;
    if (v.d2) begin
      clr2 = v.cmd[4]; if2.load_digit = v.cmd[3]; if2.start = v.cmd[2];
      if2.pause = v.cmd[1]; if2.add30 = v.cmd[0]; if2.data = v.data;
    end else begin
      clr1 = v.cmd[4]; if1.load_digit = v.cmd[3]; if1.start = v.cmd[2];
      if1.pause = v.cmd[1]; if1.add30 = v.cmd[0]; if1.data = v.data;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out();
    step++;
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    // Entry, rejected start (1:79), invalid digit, load+start, valid start.
    tbl.push_back(mk(0, CLR, 4'h0, 16'h0000, IDL, 0, 0));
    tbl.push_back(mk(0, LD,  4'h2, 16'h0002, IDL, 0, 0));
    tbl.push_back(mk(0, LD,  4'h1, 16'h0021, IDL, 0, 0));
    tbl.push_back(mk(0, LD,  4'h7, 16'h0217, IDL, 0, 0));
    tbl.push_back(mk(0, LD,  4'h9, 16'h0179, IDL, 0, 0));
    tbl.push_back(mk(0, ST,  4'h0, 16'h0179, IDL, 0, 1));
    tbl.push_back(mk(0, NOP, 4'h0, 16'h0179, IDL, 0, 0));
    tbl.push_back(mk(0, LD,  4'hC, 16'h0179, IDL, 0, 0));
    tbl.push_back(mk(0, CLR, 4'h0, 16'h0000, IDL, 0, 0));
    tbl.push_back(mk(0, LD,  4'h1, 16'h0001, IDL, 0, 0));
    tbl.push_back(mk(0, LD,  4'h3, 16'h0013, IDL, 0, 0));
    tbl.push_back(mk(0, LD|ST, 4'h5, 16'h0135, IDL, 0, 0));
    tbl.push_back(mk(0, ST,  4'h0, 16'h0135, RUN, 0, 0));
    run_tbl();

    // 1:35 counts down one second per cycle; done on the cycle 0:00 appears.
    for (int k = 1; k <= 95; k++) begin
      int t;
      t = 95 - k;
      apply(mk(0, NOP, 4'h0, {4'h0, 4'(t / 60), 4'((t % 60) / 10), 4'(t % 10)},
               (k == 95) ? IDL : RUN, k == 95, 0));
    end

    // Post-done, start at zero, quick start, saturation.
    tbl.push_back(mk(0, NOP, 4'h0, 16'h0000, IDL, 0, 0));
    tbl.push_back(mk(0, ST,  4'h0, 16'h0000, IDL, 0, 1));
    tbl.push_back(mk(0, AD,  4'h0, 16'h0030, RUN, 0, 0));
    tbl.push_back(mk(0, NOP, 4'h0, 16'h0029, RUN, 0, 0));
    tbl.push_back(mk(0, CLR, 4'h0, 16'h0000, IDL, 0, 0));
    tbl.push_back(mk(0, LD,  4'h9, 16'h0009, IDL, 0, 0));
    tbl.push_back(mk(0, LD,  4'h5, 16'h0095, IDL, 0, 0));
    tbl.push_back(mk(0, LD,  4'h0, 16'h0950, IDL, 0, 0));
    tbl.push_back(mk(0, AD,  4'h0, 16'h0959, IDL, 0, 0));
    tbl.push_back(mk(0, ST,  4'h0, 16'h0959, RUN, 0, 0));
    tbl.push_back(mk(0, NOP, 4'h0, 16'h0958, RUN, 0, 0));
    tbl.push_back(mk(0, AD,  4'h0, 16'h0959, RUN, 0, 0));
    tbl.push_back(mk(0, CLR, 4'h0, 16'h0000, IDL, 0, 0));

    // Prescaled countdown 00:02 with TICK_DIV=4.
    tbl.push_back(mk(1, CLR, 4'h0, 16'h0000, IDL, 0, 0));
    tbl.push_back(mk(1, LD,  4'h0, 16'h0000, IDL, 0, 0));
    tbl.push_back(mk(1, LD,  4'h2, 16'h0002, IDL, 0, 0));
    tbl.push_back(mk(1, ST,  4'h0, 16'h0002, RUN, 0, 0));
    repeat (3) tbl.push_back(mk(1, NOP, 4'h0, 16'h0002, RUN, 0, 0));
    repeat (4) tbl.push_back(mk(1, NOP, 4'h0, 16'h0001, RUN, 0, 0));
    tbl.push_back(mk(1, NOP, 4'h0, 16'h0000, IDL, 1, 0));
    tbl.push_back(mk(1, NOP, 4'h0, 16'h0000, IDL, 0, 0));
    run_tbl();

    // Pause with prescaler at 2, frozen 10 cycles (commands ignored), resume.
    tbl.push_back(mk(1, LD,  4'h2, 16'h0002, IDL, 0, 0));
    tbl.push_back(mk(1, ST,  4'h0, 16'h0002, RUN, 0, 0));
    repeat (3) tbl.push_back(mk(1, NOP, 4'h0, 16'h0002, RUN, 0, 0));
    repeat (3) tbl.push_back(mk(1, NOP, 4'h0, 16'h0001, RUN, 0, 0));
    tbl.push_back(mk(1, PA,  4'h0, 16'h0001, PSD, 0, 0));
    tbl.push_back(mk(1, AD,  4'h0, 16'h0001, PSD, 0, 0));
    tbl.push_back(mk(1, LD,  4'h7, 16'h0001, PSD, 0, 0));
    tbl.push_back(mk(1, PA,  4'h0, 16'h0001, PSD, 0, 0));
    repeat (6) tbl.push_back(mk(1, NOP, 4'h0, 16'h0001, PSD, 0, 0));
    tbl.push_back(mk(1, ST,  4'h0, 16'h0001, RUN, 0, 0));
    tbl.push_back(mk(1, NOP, 4'h0, 16'h0001, RUN, 0, 0));
    tbl.push_back(mk(1, NOP, 4'h0, 16'h0000, IDL, 1, 0));

    // 0:45 running, add30 on the would-be tick cycle -> 1:15 and prescaler restarts.
    tbl.push_back(mk(1, LD,  4'h4, 16'h0004, IDL, 0, 0));
    tbl.push_back(mk(1, LD,  4'h5, 16'h0045, IDL, 0, 0));
    tbl.push_back(mk(1, ST,  4'h0, 16'h0045, RUN, 0, 0));
    repeat (3) tbl.push_back(mk(1, NOP, 4'h0, 16'h0045, RUN, 0, 0));
    tbl.push_back(mk(1, AD,  4'h0, 16'h0115, RUN, 0, 0));
    repeat (3) tbl.push_back(mk(1, NOP, 4'h0, 16'h0115, RUN, 0, 0));
    tbl.push_back(mk(1, NOP, 4'h0, 16'h0114, RUN, 0, 0));

    // Borrow chain 10:00 -> 09:59, ignored entry while running, pause+add30, clear mid-prescale.
    tbl.push_back(mk(1, CLR, 4'h0, 16'h0000, IDL, 0, 0));
    tbl.push_back(mk(1, LD,  4'h1, 16'h0001, IDL, 0, 0));
    tbl.push_back(mk(1, LD,  4'h0, 16'h0010, IDL, 0, 0));
    tbl.push_back(mk(1, LD,  4'h0, 16'h0100, IDL, 0, 0));
    tbl.push_back(mk(1, LD,  4'h0, 16'h1000, IDL, 0, 0));
    tbl.push_back(mk(1, ST,  4'h0, 16'h1000, RUN, 0, 0));
    tbl.push_back(mk(1, LD,  4'h7, 16'h1000, RUN, 0, 0));
    tbl.push_back(mk(1, LD|ST, 4'h3, 16'h1000, RUN, 0, 0));
    tbl.push_back(mk(1, NOP, 4'h0, 16'h1000, RUN, 0, 0));
    tbl.push_back(mk(1, NOP, 4'h0, 16'h0959, RUN, 0, 0));
    tbl.push_back(mk(1, PA|AD, 4'h0, 16'h0959, PSD, 0, 0));
    tbl.push_back(mk(1, LD,  4'h3, 16'h0959, PSD, 0, 0));
    tbl.push_back(mk(1, ST,  4'h0, 16'h0959, RUN, 0, 0));
    tbl.push_back(mk(1, NOP, 4'h0, 16'h0959, RUN, 0, 0));
    tbl.push_back(mk(1, CLR, 4'h0, 16'h0000, IDL, 0, 0));
    tbl.push_back(mk(1, NOP, 4'h0, 16'h0000, IDL, 0, 0));

    // Quick start then +30 s with tens carry into minutes.
    tbl.push_back(mk(1, AD,  4'h0, 16'h0030, RUN, 0, 0));
    tbl.push_back(mk(1, AD,  4'h0, 16'h0100, RUN, 0, 0));
    tbl.push_back(mk(1, NOP, 4'h0, 16'h0100, RUN, 0, 0));
    tbl.push_back(mk(1, CLR, 4'h0, 16'h0000, IDL, 0, 0));
    run_tbl();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
